uart_host_ctrl: RTL and testbench

Parametrised host-side controller that sits between user I/O (buttons/switches) and the UART NIC. It queues bytes from a send button into a TX FIFO and writes them to the NIC with a ready/strobe handshake. It drains received bytes from the NIC into an RX FIFO, which the user steps through onto a display register. Wrapping sent/received counters drive the LEDs.

---
 rtl/uart_host_ctrl_if.sv | 22 ++
 rtl/uart_host_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_uart_host_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_host_ctrl_if.sv
// NIC-side handshake bundle for uart_host_ctrl: TX ready/strobe/data and RX valid/strobe/data.
// master = host controller, slave = UART NIC.
interface uart_host_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              nic_tx_ready;
  logic              write_nic;
  logic [DATA_W-1:0] send_data_to_nic;
  logic              nic_rx_valid;
  logic              read_nic;
  logic [DATA_W-1:0] rec_data_from_nic;

  modport master (
    input  nic_tx_ready, nic_rx_valid, rec_data_from_nic,
    output write_nic, read_nic, send_data_to_nic
  );

  modport slave (
    output nic_tx_ready, nic_rx_valid, rec_data_from_nic,
    input  write_nic, read_nic, send_data_to_nic
  );
endinterface

// File: rtl/uart_host_ctrl.sv
// Host-side UART NIC controller: button-driven TX FIFO, NIC-drained RX FIFO, display mux, LED counters.
// Optional 7-segment outputs D0..D2 when UART_HOST_7SEG_EN is defined (requires DATA_W=8).
`ifdef UART_HOST_7SEG_EN
module Binary_2_7SEG (
  input  logic [7:0] bin,
  output logic [7:0] d0,
  output logic [7:0] d1,
  output logic [7:0] d2
);
  function automatic logic [7:0] seg(input logic [7:0] v);
    case (v)
      8'd0:    seg = 8'h3F;
      8'd1:    seg = 8'h06;
      8'd2:    seg = 8'h5B;
      8'd3:    seg = 8'h4F;
      8'd4:    seg = 8'h66;
      8'd5:    seg = 8'h6D;
      8'd6:    seg = 8'h7D;
      8'd7:    seg = 8'h07;
      8'd8:    seg = 8'h7F;
      8'd9:    seg = 8'h6F;
      default: seg = 8'h00;
    endcase
  endfunction

  assign d2 = seg(bin / 8'd100);
  assign d1 = seg((bin / 8'd10) % 8'd10);
  assign d0 = seg(bin % 8'd10);
endmodule
`endif

module uart_host_ctrl #(
  parameter int DATA_W    = 8,
  parameter int TXQ_DEPTH = 4,
  parameter int RXQ_DEPTH = 4,
  parameter int CNT_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              send_button,
  input  logic [DATA_W-1:0] send_data_i,
  input  logic              next_button,
  input  logic              disp_sel,
  uart_host_ctrl_if.master  nic,
  output logic [DATA_W-1:0] display_data,
  output logic [CNT_W-1:0]  num_data_sent,
  output logic [CNT_W-1:0]  num_data_rcvd,
  output logic              tx_drop,
  output logic              rx_stall
`ifdef UART_HOST_7SEG_EN
  ,
  output logic [7:0]        D0,
  output logic [7:0]        D1,
  output logic [7:0]        D2
`endif
);
  localparam int TPW = $clog2(TXQ_DEPTH) + 1;
  localparam int RPW = $clog2(RXQ_DEPTH) + 1;

  typedef enum logic [1:0] {T_IDLE, T_WRITE, T_GUARD} tx_state_t;
  typedef enum logic [1:0] {R_IDLE, R_READ, R_GUARD} rx_state_t;

  tx_state_t tx_state, tx_next;
  rx_state_t rx_state, rx_next;

  logic [2:0] send_sync, next_sync;
  logic       send_pulse, next_pulse;

  logic [DATA_W-1:0] tx_mem [TXQ_DEPTH];
  logic [DATA_W-1:0] rx_mem [RXQ_DEPTH];
  logic [TPW-1:0]    tx_wr, tx_rd;
  logic [RPW-1:0]    rx_wr, rx_rd;
  logic              tx_empty, tx_full, tx_push, tx_pop;
  logic              rx_empty, rx_full, rx_push, rx_pop;
  logic [DATA_W-1:0] tx_head, rx_head, last_sent, last_rcvd;
  logic              write_nic, read_nic;
  logic [DATA_W-1:0] send_data_to_nic;

  // Two-flop synchroniser followed by a rising-edge detect on the synchronised level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      send_sync <= '0;
      next_sync <= '0;
    end else begin
      send_sync <= {send_sync[1:0], send_button};
      next_sync <= {next_sync[1:0], next_button};
    end
  end

  assign send_pulse = send_sync[1] & ~send_sync[2];
  assign next_pulse = next_sync[1] & ~next_sync[2];

  assign tx_empty = (tx_wr == tx_rd);
  assign tx_full  = (tx_wr[TPW-1] != tx_rd[TPW-1]) && (tx_wr[TPW-2:0] == tx_rd[TPW-2:0]);
  assign tx_head  = tx_mem[tx_rd[TPW-2:0]];
  assign tx_pop   = (tx_state == T_WRITE);
  assign tx_push  = send_pulse && (!tx_full || tx_pop);

  assign rx_empty = (rx_wr == rx_rd);
  assign rx_full  = (rx_wr[RPW-1] != rx_rd[RPW-1]) && (rx_wr[RPW-2:0] == rx_rd[RPW-2:0]);
  assign rx_head  = rx_mem[rx_rd[RPW-2:0]];
  assign rx_push  = (rx_state == R_READ);
  assign rx_pop   = next_pulse && !rx_empty;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr[TPW-2:0]] <= send_data_i;
    if (rx_push) rx_mem[rx_wr[RPW-2:0]] <= nic.rec_data_from_nic;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr         <= '0;
      tx_rd         <= '0;
      rx_wr         <= '0;
      rx_rd         <= '0;
      tx_drop       <= 1'b0;
      last_sent     <= '0;
      last_rcvd     <= '0;
      num_data_sent <= '0;
      num_data_rcvd <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + TPW'(1);
      if (send_pulse && tx_full && !tx_pop) tx_drop <= 1'b1;
      if (tx_pop) begin
        tx_rd         <= tx_rd + TPW'(1);
        last_sent     <= tx_head;
        num_data_sent <= num_data_sent + CNT_W'(1);
      end
      if (rx_push) begin
        rx_wr         <= rx_wr + RPW'(1);
        num_data_rcvd <= num_data_rcvd + CNT_W'(1);
      end
      if (rx_pop) begin
        rx_rd     <= rx_rd + RPW'(1);
        last_rcvd <= rx_head;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= T_IDLE;
      rx_state <= R_IDLE;
    end else begin
      tx_state <= tx_next;
      rx_state <= rx_next;
    end
  end

  // Guard states give the NIC a cycle to drop ready/valid after each strobe.
  always_comb begin
    tx_next          = tx_state;
    write_nic        = 1'b0;
    send_data_to_nic = '0;
    case (tx_state)
      T_IDLE:  if (!tx_empty && nic.nic_tx_ready) tx_next = T_WRITE;
      T_WRITE: begin
        write_nic        = 1'b1;
        send_data_to_nic = tx_head;
        tx_next          = T_GUARD;
      end
      T_GUARD: tx_next = T_IDLE;
      default: tx_next = T_IDLE;
    endcase
  end

  always_comb begin
    rx_next  = rx_state;
    read_nic = 1'b0;
    case (rx_state)
      R_IDLE:  if (nic.nic_rx_valid && !rx_full) rx_next = R_READ;
      R_READ: begin
        read_nic = 1'b1;
        rx_next  = R_GUARD;
      end
      R_GUARD: rx_next = R_IDLE;
      default: rx_next = R_IDLE;
    endcase
  end

  assign nic.write_nic        = write_nic;
  assign nic.read_nic         = read_nic;
  assign nic.send_data_to_nic = send_data_to_nic;

  assign rx_stall     = rx_full & nic.nic_rx_valid;
  assign display_data = disp_sel ? last_sent : last_rcvd;

`ifdef UART_HOST_7SEG_EN
  Binary_2_7SEG u_seg (
    .bin (display_data[7:0]),
    .d0  (D0),
    .d1  (D1),
    .d2  (D2)
  );
`endif
endmodule

// File: tb/tb_uart_host_ctrl.sv
// Scoreboard bench for uart_host_ctrl: expected NIC writes are queued by stimulus and checked by a monitor.
module tb_uart_host_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       send_button = 1'b0;
  logic [7:0] send_data_i = '0;
  logic       next_button = 1'b0;
  logic       disp_sel = 1'b0;
  logic [7:0] display_data;
  logic [3:0] num_data_sent;
  logic [3:0] num_data_rcvd;
  logic       tx_drop;
  logic       rx_stall;
`ifdef UART_HOST_7SEG_EN
  logic [7:0] D0, D1, D2;
`endif

  uart_host_ctrl_if #(.DATA_W(8)) nic_bus ();

  uart_host_ctrl #(.DATA_W(8), .TXQ_DEPTH(4), .RXQ_DEPTH(4), .CNT_W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .send_button   (send_button),
    .send_data_i   (send_data_i),
    .next_button   (next_button),
    .disp_sel      (disp_sel),
    .nic           (nic_bus),
    .display_data  (display_data),
    .num_data_sent (num_data_sent),
    .num_data_rcvd (num_data_rcvd),
    .tx_drop       (tx_drop),
    .rx_stall      (rx_stall)
`ifdef UART_HOST_7SEG_EN
    ,
    .D0            (D0),
    .D1            (D1),
    .D2            (D2)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_wr = -100;
  int rd_count = 0;
  logic [7:0] tx_exp[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: every write strobe must match the oldest queued byte and respect the 3-cycle spacing.
  initial begin
    forever begin
      @(negedge clk);
      if (nic_bus.write_nic === 1'b1) begin
        if (tx_exp.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected write_nic: data 0x%0h, expected no write", nic_bus.send_data_to_nic);
        end else begin
          check("tx byte", {24'd0, nic_bus.send_data_to_nic}, {24'd0, tx_exp.pop_front()});
          check("tx spacing >= 3", {31'd0, (cyc - last_wr) >= 3}, 32'd1);
        end
        last_wr = cyc;
      end
      if (nic_bus.read_nic === 1'b1) rd_count++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "timeout");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    wait_cycles(2);
    rst_n = 1'b1;
  endtask

  task automatic press_send(input logic [7:0] d, input int hold);
    @(posedge clk);
    #1;
    send_data_i = d;
    send_button = 1'b1;
    wait_cycles(hold);
    send_button = 1'b0;
    wait_cycles(6);
  endtask

  task automatic press_next();
    @(posedge clk);
    #1;
    next_button = 1'b1;
    wait_cycles(4);
    next_button = 1'b0;
    wait_cycles(6);
  endtask

  task automatic recv_byte(input logic [7:0] d);
    bit seen;
    seen = 1'b0;
    @(posedge clk);
    #1;
    nic_bus.rec_data_from_nic = d;
    nic_bus.nic_rx_valid = 1'b1;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (nic_bus.read_nic === 1'b1) seen = 1'b1;
    end
    check("read_nic seen", {31'd0, seen}, 32'd1);
    @(posedge clk);
    #1;
    nic_bus.nic_rx_valid = 1'b0;
  endtask

  initial begin
    bit seen;
    nic_bus.nic_tx_ready = 1'b0;
    nic_bus.nic_rx_valid = 1'b0;
    nic_bus.rec_data_from_nic = '0;
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(1);

    // Reset state
    check("reset write_nic", {31'd0, nic_bus.write_nic}, 32'd0);
    check("reset read_nic", {31'd0, nic_bus.read_nic}, 32'd0);
    check("reset send_data", {24'd0, nic_bus.send_data_to_nic}, 32'd0);
    check("reset display", {24'd0, display_data}, 32'd0);
    check("reset sent cnt", {28'd0, num_data_sent}, 32'd0);
    check("reset rcvd cnt", {28'd0, num_data_rcvd}, 32'd0);
    check("reset tx_drop", {31'd0, tx_drop}, 32'd0);
    check("reset rx_stall", {31'd0, rx_stall}, 32'd0);

    // Three sends with the NIC ready
    nic_bus.nic_tx_ready = 1'b1;
    tx_exp.push_back(8'h11); press_send(8'h11, 6);
    tx_exp.push_back(8'h22); press_send(8'h22, 6);
    tx_exp.push_back(8'h33); press_send(8'h33, 6);
    wait_cycles(5);
    check("sent cnt after 3", {28'd0, num_data_sent}, 32'd3);
    check("tx queue drained 1", tx_exp.size(), 32'd0);
    disp_sel = 1'b1; #1;
    check("display last sent", {24'd0, display_data}, 32'h33);
    disp_sel = 1'b0; #1;
    check("display last rcvd", {24'd0, display_data}, 32'h00);

    // Overfill TX FIFO while the NIC is busy
    nic_bus.nic_tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tx_exp.push_back(8'hA0 + 8'(i));
      press_send(8'hA0 + 8'(i), 6);
    end
    check("tx_drop after 4", {31'd0, tx_drop}, 32'd0);
    press_send(8'hA4, 6);
    check("tx_drop after 5", {31'd0, tx_drop}, 32'd1);
    check("no write while busy", {28'd0, num_data_sent}, 32'd3);
    nic_bus.nic_tx_ready = 1'b1;
    wait_cycles(20);
    check("tx queue drained 2", tx_exp.size(), 32'd0);
    check("sent cnt after 7", {28'd0, num_data_sent}, 32'd7);
    disp_sel = 1'b1; #1;
    check("display A3", {24'd0, display_data}, 32'hA3);
    disp_sel = 1'b0;

    // Fill RX FIFO until stall
    nic_bus.rec_data_from_nic = 8'h5A;
    nic_bus.nic_rx_valid = 1'b1;
    wait_cycles(30);
    check("reads until full", rd_count, 32'd4);
    check("rx_stall full", {31'd0, rx_stall}, 32'd1);
    check("rcvd cnt 4", {28'd0, num_data_rcvd}, 32'd4);
    press_next();
    check("display 5A", {24'd0, display_data}, 32'h5A);
    check("one more read", rd_count, 32'd5);
    check("rcvd cnt 5", {28'd0, num_data_rcvd}, 32'd5);
    check("rx_stall refilled", {31'd0, rx_stall}, 32'd1);
    nic_bus.nic_rx_valid = 1'b0;
    #1;
    check("rx_stall valid low", {31'd0, rx_stall}, 32'd0);

    // Counter wrap with distinct bytes
    do_reset();
    check("tx_drop cleared", {31'd0, tx_drop}, 32'd0);
    for (int i = 1; i <= 17; i++) begin
      recv_byte(8'(i * 7));
      press_next();
      check("rx byte display", {24'd0, display_data}, 32'(8'(i * 7)));
    end
    check("rcvd cnt wrap", {28'd0, num_data_rcvd}, 32'd1);
    check("reads total", rd_count, 32'd22);

`ifdef UART_HOST_7SEG_EN
    recv_byte(8'h7B);
    press_next();
    check("seg D2", {24'd0, D2}, 32'h06);
    check("seg D1", {24'd0, D1}, 32'h5B);
    check("seg D0", {24'd0, D0}, 32'h4F);
`endif

    // Held button gives one push
    do_reset();
    nic_bus.nic_tx_ready = 1'b0;
    tx_exp.push_back(8'hC5);
    press_send(8'hC5, 100);
    nic_bus.nic_tx_ready = 1'b1;
    wait_cycles(15);
    check("held single write", {28'd0, num_data_sent}, 32'd1);
    check("tx queue drained 3", tx_exp.size(), 32'd0);

    // Reset during T_WRITE
    nic_bus.nic_tx_ready = 1'b0;
    tx_exp.push_back(8'h77); press_send(8'h77, 6);
    tx_exp.push_back(8'h78); press_send(8'h78, 6);
    nic_bus.nic_tx_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (nic_bus.write_nic === 1'b1) seen = 1'b1;
    end
    check("write before reset", {31'd0, seen}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("write_nic drops on reset", {31'd0, nic_bus.write_nic}, 32'd0);
    check("send_data zero on reset", {24'd0, nic_bus.send_data_to_nic}, 32'd0);
    check("sent cnt zero on reset", {28'd0, num_data_sent}, 32'd0);
    disp_sel = 1'b1; #1;
    check("last sent zero on reset", {24'd0, display_data}, 32'd0);
    disp_sel = 1'b0;
    tx_exp.delete();
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(15);
    check("tx FIFO discarded", {28'd0, num_data_sent}, 32'd0);
    press_next();
    check("rx FIFO empty", {24'd0, display_data}, 32'd0);
    check("rcvd cnt after reset", {28'd0, num_data_rcvd}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
